// File: rtl/vertex_output_packer.sv
// Vertex output packer: converts 4x32-bit fixed-point matrix results to 16-bit
// saturated values, buffers up to two vectors, and streams them one component per cycle.
module vertex_output_packer #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pixelout_0,
  input  logic [31:0] pixelout_1,
  input  logic [31:0] pixelout_2,
  input  logic [31:0] pixelout_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic [15:0] sat_count,
  output logic        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and held data is stable while stalled.

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      sat_q, sat_d;
  logic [3:0][15:0] mem_q [2];
  logic [3:0][15:0] mem_d [2];

  logic [31:0]      pix [4];
  logic [31:0]      shifted [4];
  logic [3:0][15:0] conv_vec;
  logic [3:0]       conv_sat;
  logic [2:0]       sat_inc;
  logic [16:0]      sat_sum;

  logic             push;
  logic             fire;
  logic             pop;

  assign pix[0] = pixelout_0;
  assign pix[1] = pixelout_1;
  assign pix[2] = pixelout_2;
  assign pix[3] = pixelout_3;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      shifted[k]  = pix[k] >> FRAC_BITS;
      conv_sat[k] = |shifted[k][31:16];
      conv_vec[k] = conv_sat[k] ? 16'hFFFF : shifted[k][15:0];
    end
  end

  assign sat_inc = {2'b00, conv_sat[0]} + {2'b00, conv_sat[1]}
                 + {2'b00, conv_sat[2]} + {2'b00, conv_sat[3]};
  assign sat_sum = {1'b0, sat_q} + {14'd0, sat_inc};

  // in_ready looks only at occupancy, so a full FIFO never accepts in the pop cycle.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (state_q == ST_STREAM);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_data  = out_valid ? mem_q[rd_ptr_q][idx_q] : 16'h0000;
  assign sat_count = sat_q;
  assign dbg_state = state_q;

  assign push = in_valid && in_ready;
  assign fire = out_valid && out_ready;
  assign pop  = fire && (idx_q == 2'd3);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop && !push && (count_q == 2'd1)) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    sat_d    = sat_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = conv_vec;
      wr_ptr_d        = ~wr_ptr_q;
      sat_d           = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
    if (fire) idx_d = idx_q + 2'd1;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_EMPTY;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= 2'd0;
      sat_q    <= 16'h0000;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      sat_q    <= sat_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule
